// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, control/ALU decode, immediate
// generation and the ID/EX pipeline register with stall and flush.
`timescale 1ns/1ps
module decode_cycle #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_4_d,
    input  logic            stall_d,
    input  logic            flush_e,
    input  logic            reg_write_w,
    input  logic [4:0]      rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic [4:0]      rs1_d,
    output logic [4:0]      rs2_d,
    output logic            reg_write_e,
    output logic            mem_write_e,
    output logic            jump_e,
    output logic            jalr_e,
    output logic            branch_e,
    output logic            src_a_pc_e,
    output logic            alu_src_e,
    output logic            illegal_e,
    output logic [1:0]      result_src_e,
    output logic [3:0]      alu_ctrl_e,
    output logic [2:0]      funct3_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_4_e,
    output logic [4:0]      rd_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND   = 4'b0010,
        ALU_OR  = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLL   = 4'b0101,
        ALU_SRL = 4'b0110, ALU_SRA  = 4'b0111, ALU_SLT   = 4'b1000,
        ALU_SLTU = 4'b1001, ALU_PASSB = 4'b1010
    } alu_op_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            jalr;
        logic            branch;
        logic            src_a_pc;
        logic            alu_src;
        logic            illegal;
        logic [1:0]      result_src;
        logic [3:0]      alu_ctrl;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } id_ex_t;

    logic [XLEN-1:0] regs [NREGS];
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    alu_op_t         alu_arith;
    id_ex_t          id_ex_d;
    id_ex_t          id_ex_q;

    assign opcode   = instr_d[6:0];
    assign funct3   = instr_d[14:12];
    assign funct7_5 = instr_d[30];
    assign rs1_d    = instr_d[19:15];
    assign rs2_d    = instr_d[24:20];

    assign imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
    assign imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
    assign imm_b = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
    assign imm_u = {instr_d[31:12], 12'b0};
    assign imm_j = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

    // Register file write port; x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (reg_write_w && (rd_w != 5'd0)) begin
            regs[rd_w] <= result_w;
        end
    end

    // Arithmetic op from funct3; funct7[5] picks SUB only for R-type, SRA for both
    always_comb begin
        alu_arith = ALU_ADD;
        case (funct3)
            3'b000: alu_arith = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_arith = ALU_SLL;
            3'b010: alu_arith = ALU_SLT;
            3'b011: alu_arith = ALU_SLTU;
            3'b100: alu_arith = ALU_XOR;
            3'b101: alu_arith = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_arith = ALU_OR;
            default: alu_arith = ALU_AND;
        endcase
    end

    // Main decode plus bypassed register reads into the next ID/EX value
    always_comb begin
        id_ex_d          = '0;
        id_ex_d.funct3   = funct3;
        id_ex_d.rd       = instr_d[11:7];
        id_ex_d.rs1      = rs1_d;
        id_ex_d.rs2      = rs2_d;
        id_ex_d.pc       = pc_d;
        id_ex_d.pc_4     = pc_4_d;
        id_ex_d.imm_ext  = imm_i;
        id_ex_d.alu_ctrl = ALU_ADD;
        if (rs1_d != 5'd0) begin
            id_ex_d.rd1 = (reg_write_w && rd_w == rs1_d) ? result_w : regs[rs1_d];
        end
        if (rs2_d != 5'd0) begin
            id_ex_d.rd2 = (reg_write_w && rd_w == rs2_d) ? result_w : regs[rs2_d];
        end
        case (opcode)
            OP_R: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_ctrl  = alu_arith;
            end
            OP_I: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                id_ex_d.alu_ctrl  = alu_arith;
            end
            OP_LOAD: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.alu_src    = 1'b1;
                id_ex_d.result_src = 2'b01;
            end
            OP_STORE: begin
                id_ex_d.mem_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                id_ex_d.imm_ext   = imm_s;
            end
            OP_BRANCH: begin
                id_ex_d.branch   = 1'b1;
                id_ex_d.alu_ctrl = ALU_SUB;
                id_ex_d.imm_ext  = imm_b;
            end
            OP_JAL: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.jump       = 1'b1;
                id_ex_d.result_src = 2'b10;
                id_ex_d.imm_ext    = imm_j;
            end
            OP_JALR: begin
                id_ex_d.reg_write  = 1'b1;
                id_ex_d.jump       = 1'b1;
                id_ex_d.jalr       = 1'b1;
                id_ex_d.alu_src    = 1'b1;
                id_ex_d.result_src = 2'b10;
            end
            OP_LUI: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                id_ex_d.alu_ctrl  = ALU_PASSB;
                id_ex_d.imm_ext   = imm_u;
            end
            OP_AUIPC: begin
                id_ex_d.reg_write = 1'b1;
                id_ex_d.alu_src   = 1'b1;
                id_ex_d.src_a_pc  = 1'b1;
                id_ex_d.imm_ext   = imm_u;
            end
            default: id_ex_d.illegal = 1'b1;
        endcase
    end

    // ID/EX register: flush beats stall, stall holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
        end else if (flush_e) begin
            id_ex_q <= '0;
        end else if (!stall_d) begin
            id_ex_q <= id_ex_d;
        end
    end

    assign reg_write_e  = id_ex_q.reg_write;
    assign mem_write_e  = id_ex_q.mem_write;
    assign jump_e       = id_ex_q.jump;
    assign jalr_e       = id_ex_q.jalr;
    assign branch_e     = id_ex_q.branch;
    assign src_a_pc_e   = id_ex_q.src_a_pc;
    assign alu_src_e    = id_ex_q.alu_src;
    assign illegal_e    = id_ex_q.illegal;
    assign result_src_e = id_ex_q.result_src;
    assign alu_ctrl_e   = id_ex_q.alu_ctrl;
    assign funct3_e     = id_ex_q.funct3;
    assign rd1_e        = id_ex_q.rd1;
    assign rd2_e        = id_ex_q.rd2;
    assign imm_ext_e    = id_ex_q.imm_ext;
    assign pc_e         = id_ex_q.pc;
    assign pc_4_e       = id_ex_q.pc_4;
    assign rd_e         = id_ex_q.rd;
    assign rs1_e        = id_ex_q.rs1;
    assign rs2_e        = id_ex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: driver pushes modelled ID/EX contents,
// monitor pops and compares one entry after every posedge.
`timescale 1ns/1ps
module tb_decode_cycle;

    typedef struct packed {
        logic        rw, mw, j, jr, br, sa, as, il;
        logic [1:0]  rs;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rd, rs1, rs2;
        logic        imm_ok;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_d, pc_4_d, result_w;
    logic        stall_d, flush_e, reg_write_w;
    logic [4:0]  rd_w, rs1_d, rs2_d, rd_e, rs1_e, rs2_e;
    logic        reg_write_e, mem_write_e, jump_e, jalr_e, branch_e;
    logic        src_a_pc_e, alu_src_e, illegal_e;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_ctrl_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_4_e;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q[$];
    exp_t        cur;
    logic [31:0] rf [32];
    logic [31:0] pc_cnt;

    decode_cycle dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_4_d(pc_4_d),
        .stall_d(stall_d), .flush_e(flush_e), .reg_write_w(reg_write_w),
        .rd_w(rd_w), .result_w(result_w), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
        .jalr_e(jalr_e), .branch_e(branch_e), .src_a_pc_e(src_a_pc_e),
        .alu_src_e(alu_src_e), .illegal_e(illegal_e), .result_src_e(result_src_e),
        .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_4_e(pc_4_e), .rd_e(rd_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e, input string tag);
        chk({tag, " reg_write_e"}, 32'(reg_write_e), 32'(e.rw));
        chk({tag, " mem_write_e"}, 32'(mem_write_e), 32'(e.mw));
        chk({tag, " jump_e"}, 32'(jump_e), 32'(e.j));
        chk({tag, " jalr_e"}, 32'(jalr_e), 32'(e.jr));
        chk({tag, " branch_e"}, 32'(branch_e), 32'(e.br));
        chk({tag, " src_a_pc_e"}, 32'(src_a_pc_e), 32'(e.sa));
        chk({tag, " alu_src_e"}, 32'(alu_src_e), 32'(e.as));
        chk({tag, " illegal_e"}, 32'(illegal_e), 32'(e.il));
        chk({tag, " result_src_e"}, 32'(result_src_e), 32'(e.rs));
        chk({tag, " alu_ctrl_e"}, 32'(alu_ctrl_e), 32'(e.alu));
        chk({tag, " funct3_e"}, 32'(funct3_e), 32'(e.f3));
        chk({tag, " rd1_e"}, rd1_e, e.rd1);
        chk({tag, " rd2_e"}, rd2_e, e.rd2);
        if (e.imm_ok) chk({tag, " imm_ext_e"}, imm_ext_e, e.imm);
        chk({tag, " pc_e"}, pc_e, e.pc);
        chk({tag, " pc_4_e"}, pc_4_e, e.pc4);
        chk({tag, " rd_e"}, 32'(rd_e), 32'(e.rd));
        chk({tag, " rs1_e"}, 32'(rs1_e), 32'(e.rs1));
        chk({tag, " rs2_e"}, 32'(rs2_e), 32'(e.rs2));
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        e.imm_ok = 1'b1;
        return e;
    endfunction

    // ALU code for register/immediate arithmetic, straight from the ISA table
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'd0: return (is_r && alt) ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // Reference decode using shifts and masks on the raw instruction word
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [31:0] sx, imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        alt;
        e     = '0;
        op    = 7'(ins & 32'h7F);
        f3    = 3'((ins >> 12) & 32'h7);
        alt   = ((ins >> 30) & 32'h1) != 0;
        sx    = ins;
        imm_i = 32'($signed(sx) >>> 20);
        imm_s = (32'($signed(sx) >>> 20) & 32'hFFFF_FFE0) | ((ins >> 7) & 32'h1F);
        imm_b = (32'($signed(sx) >>> 19) & 32'hFFFF_F000) | ((ins << 4) & 32'h800)
              | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
        imm_u = ins & 32'hFFFF_F000;
        imm_j = (32'($signed(sx) >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000)
              | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
        e.f3  = f3;
        e.rd  = 5'((ins >> 7) & 32'h1F);
        e.rs1 = 5'((ins >> 15) & 32'h1F);
        e.rs2 = 5'((ins >> 20) & 32'h1F);
        e.rd1 = r1;
        e.rd2 = r2;
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        e.imm_ok = 1'b1;
        case (op)
            7'h33: begin e.rw = 1; e.alu = alu_of(f3, alt, 1'b1); e.imm_ok = 0; end
            7'h13: begin e.rw = 1; e.as = 1; e.alu = alu_of(f3, alt, 1'b0); e.imm = imm_i; end
            7'h03: begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.imm = imm_i; end
            7'h23: begin e.mw = 1; e.as = 1; e.imm = imm_s; end
            7'h63: begin e.br = 1; e.alu = 4'd1; e.imm = imm_b; end
            7'h6F: begin e.rw = 1; e.j = 1; e.rs = 2'b10; e.imm = imm_j; end
            7'h67: begin e.rw = 1; e.j = 1; e.jr = 1; e.as = 1; e.rs = 2'b10; e.imm = imm_i; end
            7'h37: begin e.rw = 1; e.as = 1; e.alu = 4'd10; e.imm = imm_u; end
            7'h17: begin e.rw = 1; e.as = 1; e.sa = 1; e.imm = imm_u; end
            default: begin e.il = 1; e.imm_ok = 0; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] rs, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (rs == 5'd0) return 32'd0;
        if (we && wrd == rs) return wd;
        return rf[rs];
    endfunction

    // One cycle of stimulus; expected ID/EX after the next posedge is queued
    task automatic step(input logic [31:0] ins, input logic st, input logic fl,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        exp_t        d;
        logic [4:0]  a, b;
        @(negedge clk);
        instr_d     = ins;
        pc_d        = pc_cnt;
        pc_4_d      = pc_cnt + 32'd4;
        stall_d     = st;
        flush_e     = fl;
        reg_write_w = we;
        rd_w        = wrd;
        result_w    = wd;
        a = 5'((ins >> 15) & 32'h1F);
        b = 5'((ins >> 20) & 32'h1F);
        d = model(ins, pc_cnt, rd_model(a, we, wrd, wd), rd_model(b, we, wrd, wd));
        if (fl) cur = zero_exp();
        else if (!st) cur = d;
        q.push_back(cur);
        if (we && wrd != 5'd0) rf[wrd] = wd;
        pc_cnt = pc_cnt + 32'd4;
        #1;
        chk("rs1_d", 32'(rs1_d), 32'(a));
        chk("rs2_d", 32'(rs2_d), 32'(b));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("scoreboard drained", 32'(q.size()), 32'd0);
    endtask

    // Async reset in mid-cycle; the ID/EX contents and register file must clear
    task automatic reset_dut();
        drain();
        @(negedge clk);
        stall_d     = 1'b1;
        flush_e     = 1'b0;
        reg_write_w = 1'b0;
        #2 rst = 1'b1;
        #1 compare_all(zero_exp(), "async reset");
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        cur = zero_exp();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] ins;
        int          k;
        k   = $urandom_range(0, 10);
        ins = $urandom();
        if (k < 9) begin
            ins[6:0] = ops[k];
            if (k == 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end
        return ins;
    endfunction

    task automatic random_steps(input int n);
        logic [31:0] ins;
        logic [4:0]  wrd;
        for (int i = 0; i < n; i++) begin
            ins = rand_instr();
            wrd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) wrd = ins[19:15];
            if ($urandom_range(0, 3) == 0) wrd = ins[24:20];
            step(ins, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) != 0, wrd, $urandom());
        end
    endtask

    // Monitor: one ID/EX snapshot per posedge, compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                compare_all(e, "id_ex");
            end
        end
    end

    initial begin
        rst = 1'b1; instr_d = '0; pc_d = '0; pc_4_d = '0; stall_d = 1'b1;
        flush_e = 1'b0; reg_write_w = 1'b0; rd_w = '0; result_w = '0;
        pc_cnt = 32'h0000_1000;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        cur = zero_exp();
        #12 compare_all(zero_exp(), "power-on reset");
        @(negedge clk);
        rst = 1'b0;

        // Every register reads zero after reset: add x0, xi, xi
        for (int i = 1; i < 32; i++) begin
            logic [4:0] r;
            r = 5'(i);
            step({7'h00, r, r, 3'b000, 5'd0, 7'h33}, 0, 0, 0, 5'd0, 32'd0);
        end
        step(32'h0052_8333, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);  // add x6,x5,x5 with WB bypass
        step(32'hFFF0_0093, 0, 0, 1, 5'd0, 32'h0000_1234);  // addi x1,x0,-1; x0 write dropped
        step(32'hFE00_0CE3, 0, 0, 0, 5'd0, 32'd0);          // beq x0,x0,-8
        step(32'h0010_00EF, 0, 0, 0, 5'd0, 32'd0);          // jal x1,2048
        step(32'h1234_5137, 0, 0, 0, 5'd0, 32'd0);          // lui x2,0x12345
        step(32'h0053_2423, 0, 0, 1, 5'd6, 32'h0000_0100);  // sw x5,8(x6)
        step(32'h0052_8333, 1, 0, 0, 5'd0, 32'd0);          // stalled: sw held
        step(32'hFFF0_0093, 1, 0, 1, 5'd7, 32'h0000_0077);  // stalled, WB still writes
        step(32'h0052_8333, 1, 1, 0, 5'd0, 32'd0);          // flush beats stall
        step(32'hFFFF_FFFF, 0, 0, 0, 5'd0, 32'd0);          // illegal opcode
        step(32'h0000_0000, 0, 0, 0, 5'd0, 32'd0);          // fetch reset value
        step(32'h0073_83B3, 0, 0, 0, 5'd0, 32'd0);          // add x7,x7,x7 reads written x7

        random_steps(400);
        reset_dut();
        random_steps(200);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second stage of the RV32I five-stage pipeline. Sits between the fetch stage and execute.
- Consumes the IF/ID outputs (instruction, PC, PC+4). Contains the 32x32 register file, the main/ALU control decode and immediate generation.
- Presents all execute-stage controls and operands through a registered ID/EX pipeline register with stall and flush.
- Accepts the write-back port from the WB stage.

Parameters:
- XLEN, 32, datapath width
- NREGS, 32, number of architectural registers (index width 5)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr_d  in  32  instruction from IF/ID
- pc_d  in  32  PC of instr_d
- pc_4_d  in  32  PC+4 of instr_d
- stall_d  in  1  hold ID/EX contents (hazard unit)
- flush_e  in  1  load a bubble into ID/EX (hazard unit)
- reg_write_w  in  1  WB register write enable
- rd_w  in  5  WB destination
- result_w  in  32  WB write data
- rs1_d, rs2_d  out  5 each  combinational source indices to hazard unit
- reg_write_e, mem_write_e, jump_e, jalr_e, branch_e, src_a_pc_e, alu_src_e, illegal_e  out  1 each  registered controls
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4
- alu_ctrl_e  out  4  ALU operation
- funct3_e  out  3  branch / load / store width selector
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_4_e  out  32 each  registered operands
- rd_e, rs1_e, rs2_e  out  5 each  registered indices

Behaviour:
- Latency: instr_d sampled at posedge N; decoded values valid on the _e outputs after posedge N.
- ID/EX update priority each posedge: rst > flush_e > stall_d > load.
  - rst: async clear of every _e output to 0.
  - flush_e: every _e output cleared to 0 (bubble equals a NOP with no side effects). Flush wins over a simultaneous stall_d.
  - stall_d: all _e outputs hold.
- Register file:
  - Async rst clears all entries to 0.
  - Write at posedge when reg_write_w=1 and rd_w!=0. Writes to x0 are ignored, and x0 always reads 0.
  - Reads are combinational with internal bypass: if reg_write_w=1, rd_w!=0 and rd_w equals rs1/rs2, return result_w. This covers the same-cycle WB/ID case.
  - The register file is written regardless of stall_d or flush_e.
- Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], funct3=instr[14:12].
- Immediate, always sign-extended to 32 bits:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
- ALU encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010
- Decode by opcode:
  - R 0110011: reg_write; ALU op from funct3 and funct7[5]. funct7[5] selects SUB for ADD and SRA for SRL.
  - I-ALU 0010011: reg_write, alu_src. funct7[5] is only honoured for SRAI.
  - LOAD 0000011: reg_write, alu_src, result_src=01, ADD.
  - STORE 0100011: mem_write, alu_src, ADD, S-immediate.
  - BRANCH 1100011: branch, SUB, B-immediate.
  - JAL 1101111: reg_write, jump, result_src=10, J-immediate.
  - JALR 1100111: reg_write, jump, jalr, alu_src, result_src=10, ADD, I-immediate.
  - LUI 0110111: reg_write, alu_src, PASSB, U-immediate.
  - AUIPC 0010111: reg_write, alu_src, src_a_pc, ADD, U-immediate.
  - Any other opcode: all controls 0, illegal_e=1; the data fields still load.
- instr_d=0, i.e. the fetch reset value, decodes as illegal with all controls 0. This is a harmless bubble.
- If rst is asserted mid-stream, the instruction in flight is discarded. The first valid decode follows the first posedge after rst deasserts.

Test Plan:
- Reset → all _e outputs 0. Read x1..x31 via rs fields → 0.
- WB writes x5=0xDEADBEEF with reg_write_w=1; same cycle instr_d=add x6,x5,x5 (0x00528333) → next edge: rd1_e=rd2_e=0xDEADBEEF (bypass), alu_ctrl_e=0000, rd_e=6, reg_write_e=1.
- WB writes x0=0x1234; instr_d=addi x1,x0,-1 (0xFFF00093) → rd1_e=0, imm_ext_e=0xFFFFFFFF, alu_src_e=1.
- Immediate coverage:
  - beq x0,x0,-8 (0xFE000CE3) → imm_ext_e=0xFFFFFFF8, branch_e=1.
  - jal x1,2048 (0x001000EF) → imm_ext_e=0x00000800, result_src_e=10.
  - lui x2,0x12345 (0x12345137) → imm_ext_e=0x12345000, alu_ctrl_e=1010.
- Load a valid sw, then assert stall_d for 2 cycles with a different instr_d → outputs hold the sw values (mem_write_e=1). Then assert flush_e and stall_d together → all _e outputs 0.
- instr_d=0xFFFFFFFF → illegal_e=1, reg_write_e=mem_write_e=branch_e=jump_e=0.
